// File: rtl/encoder_stage_scheduler.sv
// Contracting-path sequencer: loads BN params, then starts each
// encoder stage in order, with a watchdog on every wait.
module encoder_stage_scheduler #(
  parameter int          NUM_STAGES = 4,
  parameter int          STAGE_W    = 3,
  parameter int unsigned TIMEOUT    = 32'h00FF_FFFF,
  parameter int          TO_W       = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  abort,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic                  bn_load,
  output logic [STAGE_W-1:0]    bn_sel,
  input  logic                  bn_ack,
  output logic [STAGE_W-1:0]    cur_stage,
  output logic                  busy,
  output logic                  path_done,
  output logic                  error,
  output logic [STAGE_W-1:0]    err_stage
);

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT - 1);
  localparam logic [STAGE_W-1:0] LAST =
    STAGE_W'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_BN,
    S_WAIT_BN,
    S_START,
    S_RUN,
    S_NEXT,
    S_FINISH,
    S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [STAGE_W-1:0]    cur_stage_q, cur_stage_d;
  logic [TO_W-1:0]       wd_q, wd_d;
  logic                  error_q, error_d;
  logic [STAGE_W-1:0]    err_stage_q, err_stage_d;
  logic [NUM_STAGES-1:0] stage_start_q, stage_start_d;
  logic                  bn_load_q, bn_load_d;
  logic [STAGE_W-1:0]    bn_sel_q, bn_sel_d;
  logic                  busy_q, busy_d;
  logic                  path_done_q, path_done_d;
  logic                  done_cur;

  always_comb begin
    done_cur = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++)
      if (cur_stage_q == STAGE_W'(i))
        done_cur = stage_done[i];
  end

  always_comb begin
    state_d     = state_q;
    cur_stage_d = cur_stage_q;
    wd_d        = wd_q;
    error_d     = error_q;
    err_stage_d = err_stage_q;

    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (run) begin
          error_d     = 1'b0;
          err_stage_d = '0;
          cur_stage_d = '0;
          state_d     = S_LOAD_BN;
        end
      end
      S_LOAD_BN: begin
        wd_d    = '0;
        state_d = S_WAIT_BN;
      end
      S_WAIT_BN: begin
        if (bn_ack)
          state_d = S_START;
        else if (wd_q == TO_LAST)
          state_d = S_ERROR;
        else
          wd_d = wd_q + 1'b1;
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (done_cur)
          state_d = S_NEXT;
        else if (wd_q == TO_LAST)
          state_d = S_ERROR;
        else
          wd_d = wd_q + 1'b1;
      end
      S_NEXT: begin
        if (cur_stage_q == LAST) begin
          state_d = S_FINISH;
        end else begin
          cur_stage_d = cur_stage_q + 1'b1;
          state_d     = S_LOAD_BN;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (state_d == S_ERROR && state_q != S_ERROR) begin
      error_d     = 1'b1;
      err_stage_d = cur_stage_q;
    end

    // abort overrides everything except the sticky error record
    if (abort) begin
      state_d     = S_IDLE;
      wd_d        = '0;
      cur_stage_d = cur_stage_q;
      error_d     = error_q;
      err_stage_d = err_stage_q;
    end
  end

  always_comb begin
    stage_start_d = '0;
    if (state_d == S_START)
      for (int i = 0; i < NUM_STAGES; i++)
        stage_start_d[i] = (cur_stage_d == STAGE_W'(i));
    bn_load_d   = (state_d == S_LOAD_BN);
    bn_sel_d    = bn_load_d ? cur_stage_d : bn_sel_q;
    busy_d      = (state_d != S_IDLE) &&
                  (state_d != S_ERROR);
    path_done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cur_stage_q   <= '0;
      wd_q          <= '0;
      error_q       <= 1'b0;
      err_stage_q   <= '0;
      stage_start_q <= '0;
      bn_load_q     <= 1'b0;
      bn_sel_q      <= '0;
      busy_q        <= 1'b0;
      path_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_stage_q   <= cur_stage_d;
      wd_q          <= wd_d;
      error_q       <= error_d;
      err_stage_q   <= err_stage_d;
      stage_start_q <= stage_start_d;
      bn_load_q     <= bn_load_d;
      bn_sel_q      <= bn_sel_d;
      busy_q        <= busy_d;
      path_done_q   <= path_done_d;
    end
  end

  assign stage_start = stage_start_q;
  assign bn_load     = bn_load_q;
  assign bn_sel      = bn_sel_q;
  assign cur_stage   = cur_stage_q;
  assign busy        = busy_q;
  assign path_done   = path_done_q;
  assign error       = error_q;
  assign err_stage   = err_stage_q;

endmodule

// File: tb/tb_encoder_stage_scheduler.sv
// Directed bench for encoder_stage_scheduler with a start/bn_sel
// scoreboard fed at stimulus time and drained as the DUT emits.
module tb_encoder_stage_scheduler;

  localparam int NS = 4;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          abort = 1'b0;
  logic [NS-1:0] stage_start;
  logic [NS-1:0] stage_done = '0;
  logic          bn_load;
  logic [SW-1:0] bn_sel;
  logic          bn_ack = 1'b0;
  logic [SW-1:0] cur_stage;
  logic          busy;
  logic          path_done;
  logic          error;
  logic [SW-1:0] err_stage;

  int checks = 0;
  int errors = 0;
  int pd_cnt = 0;
  logic [NS-1:0] start_q[$];
  logic [SW-1:0] sel_q[$];

  encoder_stage_scheduler #(
    .NUM_STAGES(NS),
    .STAGE_W(SW),
    .TIMEOUT(16),
    .TO_W(24)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .abort(abort),
    .stage_start(stage_start),
    .stage_done(stage_done),
    .bn_load(bn_load),
    .bn_sel(bn_sel),
    .bn_ack(bn_ack),
    .cur_stage(cur_stage),
    .busy(busy),
    .path_done(path_done),
    .error(error),
    .err_stage(err_stage)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic observe();
    if (stage_start != '0) begin
      if (start_q.size() == 0)
        chk("start_extra", 32'(stage_start), 32'd0);
      else
        chk("start_seq", 32'(stage_start),
            32'(start_q.pop_front()));
    end
    if (bn_load) begin
      if (sel_q.size() == 0)
        chk("bn_load_extra", 32'(bn_load), 32'd0);
      else
        chk("bn_sel_seq", 32'(bn_sel),
            32'(sel_q.pop_front()));
    end
    if (path_done) pd_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic push_seq(int first, int last);
    for (int i = first; i <= last; i++) begin
      logic [NS-1:0] oh;
      oh = NS'(1) << i;
      sel_q.push_back(SW'(i));
      start_q.push_back(oh);
    end
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_bn_load(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bn_load) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    chk("bn_load_wait", 32'(bn_load), 32'd1);
  endtask

  // ack one cycle after bn_load, raise done 10 cycles after start
  task automatic stage_normal(int i, bit spur_run);
    bit ok;
    logic [NS-1:0] oh;
    oh = NS'(1) << i;
    wait_bn_load(ok);
    if (!ok) return;
    tick();
    bn_ack = 1'b1;
    run = spur_run;
    tick();
    bn_ack = 1'b0;
    run = 1'b0;
    chk("start_lat", 32'(stage_start), 32'(oh));
    repeat (10) tick();
    stage_done[i] = 1'b1;
  endtask

  task automatic finish_path(int pd_before);
    for (int n = 0; n < 10; n++) begin
      if (path_done) break;
      tick();
    end
    chk("path_done", 32'(path_done), 32'd1);
    tick();
    chk("busy_after", 32'(busy), 32'd0);
    chk("pd_count", 32'(pd_cnt - pd_before), 32'd1);
    chk("sb_empty", 32'(start_q.size() + sel_q.size()),
        32'd0);
  endtask

  initial begin
    int pd0;
    bit ok;

    // reset values
    #1;
    chk("rst_start", 32'(stage_start), 32'd0);
    chk("rst_bn_load", 32'(bn_load), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_cur", 32'(cur_stage), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // normal run
    pd0 = pd_cnt;
    push_seq(0, NS - 1);
    pulse_run();
    chk("run_lat", 32'(bn_load), 32'd1);
    chk("busy_run", 32'(busy), 32'd1);
    for (int i = 0; i < NS; i++) stage_normal(i, 1'b0);
    finish_path(pd0);
    chk("cur_hold", 32'(cur_stage), 32'(NS - 1));

    // RUN timeout at stage 2
    stage_done = '0;
    push_seq(0, 2);
    pulse_run();
    stage_normal(0, 1'b0);
    stage_normal(1, 1'b0);
    wait_bn_load(ok);
    tick();
    bn_ack = 1'b1;
    tick();
    bn_ack = 1'b0;
    tick();
    repeat (15) tick();
    chk("to_early", 32'(error), 32'd0);
    tick();
    chk("to_error", 32'(error), 32'd1);
    chk("to_err_stage", 32'(err_stage), 32'd2);
    chk("to_busy", 32'(busy), 32'd0);
    repeat (20) tick();
    chk("to_sticky", 32'(error), 32'd1);
    chk("sb_empty_to", 32'(start_q.size() + sel_q.size()),
        32'd0);

    // missing bn_ack at stage 1, restarted from ERROR
    stage_done = '0;
    sel_q.push_back(SW'(0));
    sel_q.push_back(SW'(1));
    start_q.push_back(NS'(1));
    pulse_run();
    chk("err_clear1", 32'(error), 32'd0);
    stage_normal(0, 1'b0);
    wait_bn_load(ok);
    for (int n = 0; n < 40; n++) begin
      if (error) break;
      tick();
    end
    chk("ack_error", 32'(error), 32'd1);
    chk("ack_err_stage", 32'(err_stage), 32'd1);
    chk("ack_busy", 32'(busy), 32'd0);
    stage_done = '0;
    pd0 = pd_cnt;
    push_seq(0, NS - 1);
    pulse_run();
    chk("err_clear2", 32'(error), 32'd0);
    chk("err_stage_clr", 32'(err_stage), 32'd0);
    for (int i = 0; i < NS; i++) stage_normal(i, 1'b0);
    finish_path(pd0);

    // abort together with the last stage_done
    stage_done = '0;
    pd0 = pd_cnt;
    push_seq(0, NS - 1);
    pulse_run();
    for (int i = 0; i < NS - 1; i++) stage_normal(i, 1'b0);
    wait_bn_load(ok);
    tick();
    bn_ack = 1'b1;
    tick();
    bn_ack = 1'b0;
    repeat (10) tick();
    stage_done[NS-1] = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pd", 32'(path_done), 32'd0);
    repeat (5) tick();
    chk("abort_pd_cnt", 32'(pd_cnt - pd0), 32'd0);
    chk("abort_err", 32'(error), 32'd0);

    // spurious inputs
    stage_done = '0;
    bn_ack = 1'b1;
    tick();
    bn_ack = 1'b0;
    tick();
    bn_ack = 1'b1;
    tick();
    bn_ack = 1'b0;
    chk("idle_ack_busy", 32'(busy), 32'd0);
    chk("idle_ack_load", 32'(bn_load), 32'd0);
    stage_done[NS-1] = 1'b1;
    pd0 = pd_cnt;
    push_seq(0, NS - 1);
    pulse_run();
    wait_bn_load(ok);
    tick();
    bn_ack = 1'b1;
    tick();
    bn_ack = 1'b0;
    repeat (5) tick();
    chk("spur_cur0", 32'(cur_stage), 32'd0);
    chk("spur_busy", 32'(busy), 32'd1);
    repeat (5) tick();
    stage_done[0] = 1'b1;
    stage_done[NS-1] = 1'b0;
    stage_normal(1, 1'b1);
    for (int i = 2; i < NS; i++) stage_normal(i, 1'b0);
    finish_path(pd0);

    // async reset mid WAIT_BN
    stage_done = '0;
    sel_q.push_back(SW'(0));
    pulse_run();
    wait_bn_load(ok);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_load", 32'(bn_load), 32'd0);
    chk("arst_cur", 32'(cur_stage), 32'd0);
    chk("arst_start", 32'(stage_start), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    pd0 = pd_cnt;
    push_seq(0, NS - 1);
    pulse_run();
    chk("arst_restart", 32'(bn_load), 32'd1);
    for (int i = 0; i < NS; i++) stage_normal(i, 1'b0);
    finish_path(pd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_stage_scheduler.md
Name: encoder_stage_scheduler

Overview:
- Sequences the U-Net contracting path: starts NUM_STAGES encoder blocks one at a time, in order.
- Before each start, requests BatchNorm parameter loading for that stage.
- Watches each stage's completion flag with a watchdog, then reports path done or error.
- Sits between the top-level segmentation controller and the encoder block instances plus the BN parameter loader.

Parameters:
NUM_STAGES, 4, number of encoder stages sequenced (1..8)
STAGE_W, 3, width of stage index; must satisfy 2^STAGE_W >= NUM_STAGES
TIMEOUT, 24'hFFFFFF, max cycles waited in WAIT_BN or RUN before error
TO_W, 24, watchdog counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
run  in  1  start request, sampled only in IDLE
abort  in  1  synchronous abort, any state
stage_start  out  NUM_STAGES  one-hot, 1-cycle start pulse to encoder stage i
stage_done  in  NUM_STAGES  level done flag per stage (stays high once set)
bn_load  out  1  1-cycle request to load BN params for bn_sel
bn_sel  out  STAGE_W  stage index whose BN params are requested
bn_ack  in  1  BN params loaded and stable
cur_stage  out  STAGE_W  stage currently being processed
busy  out  1  high in every state except IDLE and ERROR
path_done  out  1  1-cycle pulse when last stage completes
error  out  1  sticky watchdog error flag
err_stage  out  STAGE_W  stage index at which timeout occurred

Behaviour:
- Reset: state IDLE; all outputs 0 (stage_start=0, bn_load=0, bn_sel=0, cur_stage=0, busy=0, path_done=0, error=0, err_stage=0); watchdog=0.
- All outputs registered.
- States: IDLE, LOAD_BN, WAIT_BN, START, RUN, NEXT, FINISH, ERROR.
- IDLE:
  - on run=1: clear error/err_stage, cur_stage<=0, go LOAD_BN.
  - run while not IDLE is ignored.
- LOAD_BN: bn_load=1 and bn_sel=cur_stage for exactly one cycle; go WAIT_BN; watchdog<=0.
- WAIT_BN:
  - bn_ack=1 -> START.
  - Else watchdog increments each cycle; watchdog==TIMEOUT-1 without ack -> ERROR.
  - bn_ack outside WAIT_BN is ignored.
- START: stage_start[cur_stage]=1 for one cycle, all other bits 0; go RUN; watchdog<=0.
- RUN:
  - Only stage_done[cur_stage] is examined; other bits are ignored.
  - stage_done[cur_stage]=1 -> NEXT.
  - Timeout rule as in WAIT_BN -> ERROR.
  - stage_done is sampled from the cycle after stage_start onward. A flag already high on RUN entry counts as done.
- NEXT:
  - cur_stage==NUM_STAGES-1 -> FINISH.
  - Else cur_stage<=cur_stage+1 and go LOAD_BN; no wrap.
- FINISH: path_done=1 for one cycle; go IDLE; cur_stage holds last value until next run.
- ERROR:
  - error=1 and err_stage=cur_stage, latched on entry.
  - busy=0; stays in ERROR until run (clears error, restarts at stage 0) or abort (-> IDLE, error retained).
- abort:
  - Highest priority: from any state -> IDLE next edge.
  - stage_start, bn_load and path_done are forced 0 that cycle; watchdog cleared; error unchanged.
  - Abort with simultaneous stage_done/bn_ack: abort wins; no path_done.
- Latency (no waits):
  - run accepted at edge 0 -> bn_load high cycle 1 -> START if bn_ack in cycle 2 -> stage_start high cycle 3.
  - Per-stage overhead excluding stage runtime: 4 cycles (LOAD_BN, WAIT_BN min 1, START, NEXT).
- Reset mid-operation: asynchronous return to reset values; a pulse in flight is truncated.

Test Plan:
- Normal run, NUM_STAGES=4, bn_ack 1 cycle after each bn_load, stage_done[i] 10 cycles after stage_start[i] -> stage_start pulses 0001,0010,0100,1000 in order; bn_sel 0..3; exactly one path_done; busy low after FINISH.
- Timeout, TIMEOUT=16, stage 2 never asserts done -> error=1 exactly 16 cycles after RUN entry; err_stage=2; busy=0; no further stage_start.
- Missing bn_ack at stage 1, TIMEOUT=16 -> ERROR with err_stage=1; stage_start[1] never pulses; then run -> error clears and sequence restarts at stage 0.
- Abort asserted the same cycle stage_done[3]=1 -> IDLE next cycle; path_done never pulses; busy=0.
- Spurious inputs: stage_done[3]=1 held high during stage 0 RUN, bn_ack pulses in IDLE, run pulsed while busy -> no effect; sequence identical to the normal run.
- Async rst_n low mid-WAIT_BN for 3 cycles -> all outputs 0 immediately; after release, run restarts cleanly from stage 0.
